alu_acc: RTL
============

# alu_acc

Accumulator-based ALU that consumes the register-file read port and produces its write-back data/enable. One operation per `start` pulse. Single-cycle ops for LOAD/arith/logic/STORE; a WIDTH-cycle shift-add multiply with a busy/done handshake. Sits between the register-file output (`out`) and its `in`/`ce` inputs; the controller drives `op`/`start` and the register address.

## Interface
- `WIDTH`, 8, datapath width; must match the register file.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst`=0 resets).
- `start`  in  1  op request; sampled only when `busy`=0.
- `op`  in  3  opcode: 0 LOAD, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MUL, 7 STORE.
- `operand`  in  WIDTH  B operand, from register-file `out`.
- `acc`  out  WIDTH  accumulator value.
- `wb_data`  out  WIDTH  write-back data to register-file `in`.
- `wb_ce`  out  1  write-back enable to register-file `ce`; one-cycle pulse.
- `busy`  out  1  multiply in progress.
- `done`  out  1  one-cycle completion pulse.
- `zero`  out  1  combinational `acc == 0`.
- `carry`  out  1  carry/borrow/overflow flag (registered).

## Operation
- States: IDLE, MUL. Reset -> IDLE.
- Reset values: `acc`=0, `carry`=0, `zero`=1, `busy`=0, `done`=0, `wb_ce`=0, `wb_data`=0; multiply registers cleared.
- IDLE, `start`=1 at edge E0:
  - LOAD: `acc`<=`operand`, `carry`<=0.
  - ADD: {`carry`,`acc`} <= `acc`+`operand` (WIDTH+1-bit sum).
  - SUB: `acc` <= `acc`-`operand` mod 2^WIDTH; `carry`<=1 iff `operand` > `acc` (borrow).
  - AND/OR/XOR: bitwise into `acc`, `carry`<=0.
  - STORE: `wb_data`<=`acc`, `wb_ce`<=1; `acc`/`carry` unchanged.
  - MUL: latch multiplicand=`acc` (zero-extended to 2·WIDTH), multiplier=`operand`, product=0, count=0; state<=MUL, `busy`<=1.
  - Every op except MUL: `done`<=1 for exactly one cycle.
- MUL, each edge: if multiplier[0], product += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. On the WIDTH-th iteration: `acc`<=product[WIDTH-1:0], `carry`<=|product[2·WIDTH-1:WIDTH], `busy`<=0, `done`<=1, state<=IDLE.
- `operand` is latched at E0; changes during MUL have no effect.
- `start` while `busy`=1 is ignored (not queued).
- `start`=0 in IDLE: everything holds; `done`/`wb_ce` return to 0.
- `wb_data` holds its last STORE value between stores.
- Reset mid-multiply: immediate return to IDLE with reset values; partial product discarded.

## Timing
- Cycle of `start` = cycle 0 (edge E0 at its end).
- Non-MUL ops: new `acc`/`carry`/`zero` visible in cycle 1; `done`=1 in cycle 1 only; STORE: `wb_ce`=1 and `wb_data` valid in cycle 1 only. Next `start` may be issued in cycle 1 (back-to-back, one op per cycle).
- MUL: `busy`=1 in cycles 1..WIDTH; `acc`/`carry` unchanged during those cycles; final value, `done`=1, `busy`=0 in cycle WIDTH+1. Earliest accepted next `start`: cycle WIDTH+1.
- `done` and `busy` never high in the same cycle.
- `wb_ce` never asserts except in the cycle after an accepted STORE.

## Test plan
- Reset (`rst`=0 asynchronously, mid-cycle) -> `acc`=0x00, `zero`=1, `carry`=0, `busy`=`done`=`wb_ce`=0 immediately, without a clock edge.
- LOAD 0x7F; ADD 0x01; ADD 0x80, back-to-back -> `acc` 0x7F, 0x80 (`carry` 0), then 0x00 with `carry`=1, `zero`=1; `done` high in each of cycles 1..3.
- LOAD 0x05; SUB 0x07 -> `acc`=0xFE, `carry`=1; then XOR 0xFE -> `acc`=0x00, `carry`=0, `zero`=1.
- LOAD 0x0C; MUL 0x0D (`operand` toggled randomly after E0) -> `busy` in cycles 1..8, `acc`=0x9C, `carry`=0, `done` in cycle 9; LOAD 0x20; MUL 0x10 -> `acc`=0x00, `carry`=1; `start`=1 during `busy` -> no effect.
- LOAD 0xA5; STORE -> `wb_ce`=1 with `wb_data`=0xA5 for exactly one cycle, `acc` still 0xA5, `done` coincident with `wb_ce`.
- MUL started, `rst` asserted in cycle 4 -> IDLE, `acc`=0, `busy`=0, no `done`; after release, LOAD 0x03 completes normally in one cycle.

Source files
------------

// File: rtl/alu_acc.sv
// Accumulator ALU between register-file read port and write-back.
// Single-cycle logic/arith ops plus a WIDTH-cycle shift-add multiply.
module alu_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_ce,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             carry
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam int PW = 2 * WIDTH;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_AND   = 3'd3;
  localparam logic [2:0] OP_OR    = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;
  localparam logic [2:0] OP_MUL   = 3'd6;
  localparam logic [2:0] OP_STORE = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t           r_state;
  state_t           w_state_n;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_n;
  logic             r_carry;
  logic             w_carry_n;
  logic             r_done;
  logic             w_done_n;
  logic             r_wb_ce;
  logic             w_wb_ce_n;
  logic [WIDTH-1:0] r_wb_data;
  logic [WIDTH-1:0] w_wb_data_n;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    w_mcand_n;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] w_mplier_n;
  logic [PW-1:0]    r_prod;
  logic [PW-1:0]    w_prod_n;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_n;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [PW-1:0]    w_step;

  assign w_sum  = {1'b0, r_acc} + {1'b0, operand};
  // bit WIDTH of the extended difference is the borrow
  assign w_diff = {1'b0, r_acc} - {1'b0, operand};
  assign w_step = r_prod + (r_mplier[0] ? r_mcand : '0);

  always_comb begin
    w_state_n   = r_state;
    w_acc_n     = r_acc;
    w_carry_n   = r_carry;
    w_done_n    = 1'b0;
    w_wb_ce_n   = 1'b0;
    w_wb_data_n = r_wb_data;
    w_mcand_n   = r_mcand;
    w_mplier_n  = r_mplier;
    w_prod_n    = r_prod;
    w_cnt_n     = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_done_n = 1'b1;
          unique case (op)
            OP_LOAD: begin
              w_acc_n   = operand;
              w_carry_n = 1'b0;
            end
            OP_ADD: begin
              w_acc_n   = w_sum[WIDTH-1:0];
              w_carry_n = w_sum[WIDTH];
            end
            OP_SUB: begin
              w_acc_n   = w_diff[WIDTH-1:0];
              w_carry_n = w_diff[WIDTH];
            end
            OP_AND: begin
              w_acc_n   = r_acc & operand;
              w_carry_n = 1'b0;
            end
            OP_OR: begin
              w_acc_n   = r_acc | operand;
              w_carry_n = 1'b0;
            end
            OP_XOR: begin
              w_acc_n   = r_acc ^ operand;
              w_carry_n = 1'b0;
            end
            OP_MUL: begin
              w_done_n   = 1'b0;
              w_mcand_n  = {{WIDTH{1'b0}}, r_acc};
              w_mplier_n = operand;
              w_prod_n   = '0;
              w_cnt_n    = '0;
              w_state_n  = S_MUL;
            end
            OP_STORE: begin
              w_wb_data_n = r_acc;
              w_wb_ce_n   = 1'b1;
            end
          endcase
        end
      end
      S_MUL: begin
        w_prod_n   = w_step;
        w_mcand_n  = r_mcand << 1;
        w_mplier_n = r_mplier >> 1;
        w_cnt_n    = r_cnt + CW'(1);
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_acc_n   = w_step[WIDTH-1:0];
          w_carry_n = |w_step[PW-1:WIDTH];
          w_done_n  = 1'b1;
          w_state_n = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_carry   <= 1'b0;
      r_done    <= 1'b0;
      r_wb_ce   <= 1'b0;
      r_wb_data <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_prod    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_acc     <= w_acc_n;
      r_carry   <= w_carry_n;
      r_done    <= w_done_n;
      r_wb_ce   <= w_wb_ce_n;
      r_wb_data <= w_wb_data_n;
      r_mcand   <= w_mcand_n;
      r_mplier  <= w_mplier_n;
      r_prod    <= w_prod_n;
      r_cnt     <= w_cnt_n;
    end
  end

  assign acc     = r_acc;
  assign carry   = r_carry;
  assign done    = r_done;
  assign wb_ce   = r_wb_ce;
  assign wb_data = r_wb_data;
  assign busy    = (r_state == S_MUL);
  assign zero    = (r_acc == '0);

endmodule
